// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and stall control for the five-stage pipeline.
// Tracks destinations of ID/EX, EX/MEM and MEM/WR in a shadow scoreboard.
module pipe_hazard_unit #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rw,
    input  logic              id_regwr,
    input  logic              id_load,
    input  logic              id_store,
    input  logic              ex_br_taken,
    output logic              hold_if,
    output logic              hold_id,
    output logic              hold_mem,
    output logic              bubble_ex,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rw;
        logic              regwr;
        logic              load;
        logic              mem_op;
    } ent_t;

    localparam logic [2:0] C_FRZ = 3'(MEM_LAT - 1);

    ent_t              r_ex;
    ent_t              r_mem;
    ent_t              r_wb;
    logic [REG_AW-1:0] r_ex_rs;
    logic [REG_AW-1:0] r_ex_rt;
    logic              r_ex_urs;
    logic              r_ex_urt;
    logic [2:0]        r_fcnt;
    logic [CNT_W-1:0]  r_stall;
    logic [CNT_W-1:0]  r_flush;

    ent_t w_id_ent;
    logic w_frz;
    logic w_br;
    logic w_lu_raw;
    logic w_lu;
    logic w_flush;
    logic w_unused;

    function automatic logic [1:0] fsel(
        input ent_t              m,
        input ent_t              w,
        input logic [REG_AW-1:0] src,
        input logic              u
    );
        logic [1:0] s;
        s = 2'b00;
        if (u && m.valid && m.regwr && !m.load
            && (m.rw != '0) && (m.rw == src))
            s = 2'b01;
        else if (u && w.valid && w.regwr
                 && (w.rw != '0) && (w.rw == src))
            s = 2'b10;
        return s;
    endfunction

    assign w_id_ent = '{
        valid:  id_valid,
        rw:     id_rw,
        regwr:  id_regwr,
        load:   id_load,
        mem_op: id_load | id_store
    };

    assign w_frz = (r_fcnt != 3'd0);
    // Gated by reset so a held branch input cannot leak out during reset
    assign w_br  = rst_n & ex_br_taken;

    assign w_lu_raw = r_ex.valid & r_ex.load & (r_ex.rw != '0)
                    & id_valid
                    & ((id_uses_rs & (id_rs == r_ex.rw))
                     | (id_uses_rt & (id_rt == r_ex.rw)));

    assign w_flush = w_br & ~w_frz;
    assign w_lu    = w_lu_raw & ~w_frz & ~w_br;

    assign hold_if    = w_frz | w_lu;
    assign hold_id    = w_frz | w_lu;
    assign hold_mem   = w_frz;
    assign bubble_ex  = w_lu;
    assign flush_ifid = w_flush;
    assign flush_idex = w_flush;

    assign fwd_a = r_ex.valid ? fsel(r_mem, r_wb, r_ex_rs, r_ex_urs) : 2'b00;
    assign fwd_b = r_ex.valid ? fsel(r_mem, r_wb, r_ex_rt, r_ex_urt) : 2'b00;

    assign stall_cnt = r_stall;
    assign flush_cnt = r_flush;

    assign w_unused = ^{r_wb.load, r_wb.mem_op};

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex     <= '0;
            r_mem    <= '0;
            r_wb     <= '0;
            r_ex_rs  <= '0;
            r_ex_rt  <= '0;
            r_ex_urs <= 1'b0;
            r_ex_urt <= 1'b0;
            r_fcnt   <= 3'd0;
        end else if (w_frz) begin
            r_fcnt <= r_fcnt - 3'd1;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (w_flush || w_lu) begin
                r_ex     <= '0;
                r_ex_rs  <= '0;
                r_ex_rt  <= '0;
                r_ex_urs <= 1'b0;
                r_ex_urt <= 1'b0;
            end else begin
                r_ex     <= w_id_ent;
                r_ex_rs  <= id_rs;
                r_ex_rt  <= id_rt;
                r_ex_urs <= id_uses_rs;
                r_ex_urt <= id_uses_rt;
            end
            // A memory op entering EX/MEM starts its freeze window
            if (r_ex.valid && r_ex.mem_op)
                r_fcnt <= C_FRZ;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            if ((w_frz || w_lu) && !(&r_stall))
                r_stall <= r_stall + 1'b1;
            if (w_flush && !(&r_flush))
                r_flush <= r_flush + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: table of per-cycle vectors
// plus sequences for saturation, freeze and reset abort.
module tb_pipe_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic [4:0] id_rw;
    logic       id_regwr;
    logic       id_load;
    logic       id_store;
    logic       ex_br_taken;

    logic       a_hif, a_hid, a_hmem, a_bub, a_fli, a_fle;
    logic [1:0] a_fa, a_fb;
    logic [3:0] a_sc, a_fc;
    logic       b_hif, b_hid, b_hmem, b_bub, b_fli, b_fle;
    logic [1:0] b_fa, b_fb;
    logic [15:0] b_sc, b_fc;

    pipe_hazard_unit #(.REG_AW(5), .MEM_LAT(1), .CNT_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rw(id_rw), .id_regwr(id_regwr),
        .id_load(id_load), .id_store(id_store),
        .ex_br_taken(ex_br_taken),
        .hold_if(a_hif), .hold_id(a_hid), .hold_mem(a_hmem),
        .bubble_ex(a_bub), .flush_ifid(a_fli), .flush_idex(a_fle),
        .fwd_a(a_fa), .fwd_b(a_fb),
        .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    pipe_hazard_unit #(.REG_AW(5), .MEM_LAT(3), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rw(id_rw), .id_regwr(id_regwr),
        .id_load(id_load), .id_store(id_store),
        .ex_br_taken(ex_br_taken),
        .hold_if(b_hif), .hold_id(b_hid), .hold_mem(b_hmem),
        .bubble_ex(b_bub), .flush_ifid(b_fli), .flush_idex(b_fle),
        .fwd_a(b_fa), .fwd_b(b_fb),
        .stall_cnt(b_sc), .flush_cnt(b_fc)
    );

    // {hold_if, hold_id, hold_mem, bubble, flush_ifid, flush_idex, fa, fb}
    wire [9:0] w_a = {a_hif, a_hid, a_hmem, a_bub, a_fli, a_fle, a_fa, a_fb};
    wire [9:0] w_b = {b_hif, b_hid, b_hmem, b_bub, b_fli, b_fle, b_fa, b_fb};

    localparam logic [9:0] E0 = 10'b0000000000;
    localparam logic [9:0] LU = 10'b1101000000;
    localparam logic [9:0] FL = 10'b0000110000;
    localparam logic [9:0] FZ = 10'b1110000000;

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] rw;
        logic       wr;
        logic       ld;
        logic       st;
        logic       br;
        logic [9:0] exp;
    } vec_t;

    int checks = 0;
    int failures = 0;

    initial clk = 1'b1;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic v, input logic [4:0] rs, input logic [4:0] rt,
        input logic urs, input logic urt, input logic [4:0] rw,
        input logic wr, input logic ld, input logic st,
        input logic br, input logic [9:0] exp
    );
        vec_t t;
        t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt;
        t.rw = rw; t.wr = wr; t.ld = ld; t.st = st; t.br = br;
        t.exp = exp;
        return t;
    endfunction

    function automatic vec_t nop(input logic [9:0] exp);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, exp);
    endfunction

    function automatic vec_t rr(
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rw,
        input logic br, input logic [9:0] exp
    );
        return mk(1, rs, rt, 1, 1, rw, 1, 0, 0, br, exp);
    endfunction

    function automatic vec_t lw(
        input logic [4:0] rs, input logic [4:0] rw, input logic [9:0] exp
    );
        return mk(1, rs, 0, 1, 0, rw, 1, 1, 0, 0, exp);
    endfunction

    function automatic vec_t sw(
        input logic [4:0] rs, input logic [4:0] rt, input logic [9:0] exp
    );
        return mk(1, rs, rt, 1, 1, 0, 0, 0, 1, 0, exp);
    endfunction

    task automatic drive(input vec_t t);
        id_valid    = t.v;
        id_rs       = t.rs;
        id_rt       = t.rt;
        id_uses_rs  = t.urs;
        id_uses_rt  = t.urt;
        id_rw       = t.rw;
        id_regwr    = t.wr;
        id_load     = t.ld;
        id_store    = t.st;
        ex_br_taken = t.br;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #2;
    endtask

    vec_t tbl[25];

    initial begin
        tbl[0]  = nop(E0);
        tbl[1]  = rr(1, 2, 3, 0, E0);
        tbl[2]  = rr(3, 5, 4, 0, E0);
        tbl[3]  = nop(10'h004);
        tbl[4]  = rr(1, 2, 3, 0, E0);
        tbl[5]  = rr(7, 8, 6, 0, E0);
        tbl[6]  = rr(3, 5, 4, 0, E0);
        tbl[7]  = nop(10'h008);
        tbl[8]  = rr(1, 2, 3, 0, E0);
        tbl[9]  = rr(10, 11, 3, 0, E0);
        tbl[10] = rr(3, 3, 9, 0, E0);
        tbl[11] = nop(10'h005);
        tbl[12] = lw(1, 3, E0);
        tbl[13] = rr(3, 3, 4, 0, LU);
        tbl[14] = rr(3, 3, 4, 0, E0);
        tbl[15] = nop(10'h00A);
        tbl[16] = rr(1, 2, 0, 0, E0);
        tbl[17] = lw(1, 0, E0);
        tbl[18] = rr(0, 0, 5, 0, E0);
        tbl[19] = rr(1, 2, 0, 0, E0);
        tbl[20] = rr(0, 0, 5, 0, E0);
        tbl[21] = nop(E0);
        tbl[22] = lw(1, 3, E0);
        tbl[23] = rr(3, 3, 4, 1, FL);
        tbl[24] = nop(E0);

        rst_n = 1'b0;
        drive(nop(E0));
        #2;
        chk("rst_outs_a", {22'd0, w_a}, {22'd0, E0});
        chk("rst_cnts_a", {24'd0, a_sc, a_fc}, 32'd0);
        #5;
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("row%0d", i), {22'd0, w_a}, {22'd0, tbl[i].exp});
            next_cycle();
        end
        chk("stall_cnt_1", {28'd0, a_sc}, 32'd1);
        chk("flush_cnt_1", {28'd0, a_fc}, 32'd1);

        for (int i = 0; i < 20; i++) begin
            drive(lw(1, 3, E0));
            next_cycle();
            drive(rr(3, 3, 4, 0, LU));
            #1;
            chk($sformatf("sat_stall%0d", i), {22'd0, w_a}, {22'd0, LU});
            next_cycle();
            drive(rr(3, 3, 4, 0, E0));
            next_cycle();
        end
        chk("stall_cnt_sat", {28'd0, a_sc}, 32'd15);

        drive(nop(E0));
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        next_cycle();

        drive(sw(1, 2, E0));
        #1; chk("frz_c0", {22'd0, w_b}, {22'd0, E0});
        next_cycle();
        drive(rr(5, 6, 4, 0, E0));
        #1; chk("frz_c1", {22'd0, w_b}, {22'd0, E0});
        next_cycle();
        drive(rr(7, 8, 6, 1, E0));
        #1; chk("frz_c2", {22'd0, w_b}, {22'd0, FZ});
        next_cycle();
        #1; chk("frz_c3", {22'd0, w_b}, {22'd0, FZ});
        next_cycle();
        #1; chk("frz_c4_flush", {22'd0, w_b}, {22'd0, FL});
        next_cycle();
        drive(sw(1, 2, E0));
        #1; chk("frz_c5", {22'd0, w_b}, {22'd0, E0});
        chk("frz_stall_cnt", {16'd0, b_sc}, 32'd2);
        chk("frz_flush_cnt", {16'd0, b_fc}, 32'd1);
        next_cycle();
        drive(nop(E0));
        #1; chk("frz_c6", {22'd0, w_b}, {22'd0, E0});
        next_cycle();
        #1; chk("frz_c7", {22'd0, w_b}, {22'd0, FZ});

        drive(rr(3, 3, 4, 1, E0));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_frz", {22'd0, w_b}, {22'd0, E0});
        chk("rst_mid_cnt", {b_sc, b_fc}, 32'd0);
        drive(nop(E0));
        rst_n = 1'b1;
        #1;
        chk("rst_release", {22'd0, w_b}, {22'd0, E0});
        next_cycle();
        drive(rr(3, 3, 4, 0, E0));
        #1;
        chk("post_rst", {22'd0, w_b}, {22'd0, E0});
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard, forwarding and stall controller for the five-stage pipeline (IF, ID, EX, MEM, WR). It replaces the empty hazard stub. It keeps its own shadow scoreboard of destination registers for the ID/EX, EX/MEM and MEM/WR stages. From that scoreboard it drives:
- EX operand forwarding selects,
- load-use stalls,
- taken-branch flushes,
- whole-pipe freezes for multi-cycle data memory.

It also counts stall and flush cycles for performance analysis.

## Interface
Parameters:
- REG_AW, 5: register index width.
- MEM_LAT, 1: data-memory cycles per load or store (1..8). 1 means single-cycle with no freeze.
- CNT_W, 16: performance counter width.

Ports:
- clk  in  1  pipeline clock. All state updates on the falling edge, matching the pipeline registers.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_AW  ID source indices.
- id_uses_rs, id_uses_rt  in  1  ID instruction reads rs / rt.
- id_rw  in  REG_AW  ID destination index, already resolved through RegDst.
- id_regwr  in  1  ID instruction writes the register file.
- id_load, id_store  in  1  ID instruction is lw / sw.
- ex_br_taken  in  1  the branch currently in EX resolved taken.
- hold_if  out  1  hold PC and IF/ID.
- hold_id  out  1  hold ID/EX.
- hold_mem  out  1  hold EX/MEM and MEM/WR (freeze).
- bubble_ex  out  1  load zero controls into ID/EX at the next edge.
- flush_ifid, flush_idex  out  1  squash IF/ID and ID/EX at the next edge.
- fwd_a, fwd_b  out  2  EX operand select: 00 = ID/EX bus, 01 = EX/MEM ALUout, 10 = MEM/WR busW.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- Scoreboard: three entries, ID/EX, EX/MEM and MEM/WR.
  - Each entry holds {valid, rw, regwr, load, mem_op}.
  - The ID/EX entry also holds {rs, rt, uses_rs, uses_rt}.
  - Entries advance on each falling edge unless held.
  - A bubble or flush writes valid=0 into ID/EX.
- Register 0 never matches: no hazard, no forward.
- Forwarding, computed for the EX entry:
  - fwd_a = 01 if the EX/MEM entry is valid, has regwr, is not a load, rw≠0 and rw==EX.rs with uses_rs.
  - Otherwise fwd_a = 10 if the MEM/WR entry is valid, has regwr, rw≠0 and matches EX.rs.
  - Otherwise 00.
  - fwd_b is computed the same way against rt.
  - EX/MEM has priority over MEM/WR (youngest producer wins).
- Load-use: the EX entry is a valid load with rw≠0, id_valid=1, and the load's rw matches a used ID source. Response:
  - hold_if=1, hold_id=1, bubble_ex=1 for one cycle;
  - the load advances; on the next cycle the ID instruction is re-evaluated.
- Branch: ex_br_taken=1 gives flush_ifid=1 and flush_idex=1 in the same cycle.
  - The two younger instructions become invalid.
  - A flush suppresses a concurrent load-use stall: hold_if=0, hold_id=0, bubble_ex=0.
- Freeze: when a valid mem_op entry enters EX/MEM and MEM_LAT>1, the freeze counter loads MEM_LAT-1.
  - While the counter is nonzero: hold_if=hold_id=hold_mem=1, no bubbles, no flushes taken.
  - ex_br_taken is ignored, because the branch is still in EX and is re-presented afterwards.
  - The counter decrements each edge.
- Priority: freeze > flush > load-use.
- Counters:
  - stall_cnt increments on each load-use or freeze cycle.
  - flush_cnt increments on each cycle with flush_idex=1.
  - Both saturate at all-ones and do not wrap.

## Timing
- Reset (asynchronous, immediate):
  - all scoreboard entries invalid;
  - freeze counter 0;
  - counters 0;
  - all outputs 0, including fwd_a/fwd_b=00.
- Outputs are combinational from scoreboard state and the ID inputs, valid within the same cycle, and sampled by the pipeline at the falling edge.
- Load-use penalty: 1 cycle. Taken-branch penalty: 2 cycles. Each memory op freezes for MEM_LAT-1 cycles.
- Reset asserted mid-freeze or mid-stall aborts it. After release, the first edge sees an empty pipe.
- Back-to-back memory ops each freeze for the full duration, with no overlap.

## Test plan
- add $3,$1,$2 followed by sub $4,$3,$5 -> in the sub's EX cycle fwd_a=01; with one independent instruction between them, fwd_a=10.
- lw $3,0($1) followed by add $4,$3,$3 -> exactly one cycle of hold_if=hold_id=bubble_ex=1, then fwd_a=fwd_b=10, and stall_cnt=1.
- Writes to and reads of $0 in every stage combination -> fwd always 00, no stall.
- ex_br_taken=1 while ID holds a load-use consumer -> flush_ifid=flush_idex=1, bubble_ex=0, flush_cnt=1.
- MEM_LAT=3: a sw enters MEM -> hold_mem=1 for exactly 2 cycles, and ex_br_taken asserted in the same cycles is not flushed until the freeze ends.
- CNT_W=4: 20 load-use stalls -> stall_cnt holds at 15; async reset mid-freeze -> all outputs 0 immediately.
